muldiv_seq: RTL and testbench
=============================

Name: muldiv_seq

Overview:
- Multi-cycle sequencer that computes RV32M unsigned MUL, MULHU, DIVU and REMU.
- It does not have its own adder. It drives the shared 32-bit combinational ALU (alu_op/src_op1/src_op2 → alu_out) for two phases per bit.
- Sits beside the execute stage. The execute stage issues via a valid/ready request and takes the result via a valid/ready response.
- While busy, it owns the ALU input mux.

Parameters:
- ALU_ADD, 4'd0, alu_op encoding for add; must match the ALU decoder.
- ALU_SUB, 4'd1, alu_op encoding for subtract.
- ALU_SLTU, 4'd3, alu_op encoding for unsigned less-than.
- ALU_SGEU, 4'd5, alu_op encoding for unsigned greater-or-equal.

Ports:
- clk  in  1  clock; all state on rising edge
- rst  in  1  synchronous, active-high reset
- kill  in  1  abort current operation (pipeline flush)
- req_valid  in  1  request valid
- req_ready  out  1  sequencer can accept a request
- req_op  in  2  00 MUL, 01 MULHU, 10 DIVU, 11 REMU
- req_a  in  32  multiplicand / dividend
- req_b  in  32  multiplier / divisor
- resp_valid  out  1  result valid
- resp_ready  in  1  consumer takes result
- resp_data  out  32  result
- busy  out  1  high in any state except IDLE
- alu_op  out  4  to ALU alu_op
- alu_src1  out  32  to ALU src_op1
- alu_src2  out  32  to ALU src_op2
- alu_result  in  32  from ALU alu_out, sampled in the same cycle

Behaviour:
- Reset values:
  - State IDLE, req_ready=1, resp_valid=0, resp_data=0, busy=0.
  - alu_op=ALU_ADD, alu_src1=0, alu_src2=0.
  - Iteration counter 0; all datapath registers 0.
- States: IDLE, PH_A, PH_B, DONE.
- In IDLE and DONE the ALU outputs are ADD/0/0. In PH_A and PH_B they are decoded combinationally from state and registers.
- Accept: on req_valid & req_ready, latch op, a, b and set cnt=0.
  - MUL/MULHU: hi=0, lo=req_b, mc=req_a.
  - DIVU/REMU: rem=0, quo=req_a, dv=req_b.
  - Next state PH_A.
- MUL PH_A:
  - addend = lo[0] ? mc : 0.
  - ALU ADD(hi, addend); tmp <= alu_result; addend_r <= addend.
  - Next state PH_B.
- MUL PH_B:
  - ALU SLTU(tmp, addend_r); carry = alu_result[0].
  - hi <= {carry, tmp[31:1]}; lo <= {tmp[0], lo[31:1]}.
- DIV PH_A:
  - sh = {rem[30:0], quo[31]}; ALU SGEU(sh, dv).
  - ge <= rem[31] | alu_result[0]. rem[31] forces ge because the implicit 33-bit value exceeds any divisor.
  - tmp <= sh.
- DIV PH_B:
  - ALU SUB(tmp, dv).
  - rem <= ge ? alu_result : tmp (mod 2^32 is correct); quo <= {quo[30:0], ge}.
- PH_B transitions:
  - cnt==31 → DONE.
  - Otherwise cnt++ → PH_A.
- Result on entering DONE: resp_data <= MUL:lo, MULHU:hi, DIVU:quo, REMU:rem.
- Latency: fixed. resp_valid rises exactly 64 clocks after the accepting edge (32 iterations × 2 phases), independent of data.
- DONE:
  - resp_valid=1; resp_data held stable while resp_ready=0.
  - On resp_ready → IDLE, resp_valid=0.
  - req_ready=0 in DONE, so there is at least 1 idle cycle between back-to-back operations.
- Divide by zero: falls out of the algorithm with no special case. quo=0xFFFFFFFF, rem=dividend (RISC-V semantics).
- kill: in any state forces IDLE on the next edge and drops resp_valid.
  - No response is produced for the killed operation.
  - kill has priority over accept: a request with kill=1 in IDLE is not accepted.
- rst: mid-operation has the same effect as kill and also clears all registers to reset values.
- busy = (state != IDLE).

Test Plan:
- MUL a=7, b=6 → resp_data=42, resp_valid exactly 64 clocks after accept; check alu_op alternates ADD/SLTU every cycle.
- MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE; MUL same operands → 0x00000001 (exercises carry phase).
- DIVU 100/7 → 14; REMU 100/7 → 2; DIVU 0xFFFFFFFE/0x80000001 → 1, REMU → 0x7FFFFFFD (rem[31] forced-ge path).
- DIVU 0x1234/0 → 0xFFFFFFFF; REMU 0x1234/0 → 0x1234.
- Start DIVU, assert kill at cycle 20 → IDLE next edge, no resp_valid; new MUL 3×5 issued next cycle → 15. Repeat using rst instead of kill → outputs return to reset values.
- Hold resp_ready=0 for 10 cycles in DONE → resp_valid and resp_data stable and req_ready=0; release → IDLE next edge, next request accepted one cycle later.

Source files
------------

// File: rtl/muldiv_seq.sv
// muldiv_seq: multi-cycle unsigned RV32M sequencer (MUL, MULHU, DIVU, REMU).
//
// The block has no adder of its own. It borrows the shared 32-bit
// combinational ALU for two phases per bit (PH_A, PH_B), which gives
// 32 iterations x 2 phases = 64 cycles from accept to result.
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   kill              abort the current operation (pipeline flush)
//   req_valid/ready   request handshake; req_op/req_a/req_b are the operands
//   resp_valid/ready  response handshake; resp_data is the result
//   busy              high in any state except IDLE
//   alu_op/src1/src2  drive the shared ALU while busy (ADD/0/0 otherwise)
//   alu_result        ALU output, sampled in the same cycle
//
// Handshake rule: a transfer happens on a rising clk edge where valid and
// ready are both high; valid, once raised, holds its payload until that edge.
// The request side accepts only in IDLE; the response side presents in DONE.
module muldiv_seq #(
  parameter logic [3:0] ALU_ADD  = 4'd0,
  parameter logic [3:0] ALU_SUB  = 4'd1,
  parameter logic [3:0] ALU_SLTU = 4'd3,
  parameter logic [3:0] ALU_SGEU = 4'd5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        kill,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_data,
  output logic        busy,
  output logic [3:0]  alu_op,
  output logic [31:0] alu_src1,
  output logic [31:0] alu_src2,
  input  logic [31:0] alu_result
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PH_A = 2'd1,
    PH_B = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      state;
  logic [1:0]  op_r;      // 00 MUL, 01 MULHU, 10 DIVU, 11 REMU
  logic [4:0]  cnt;       // iteration index, 0..31
  // acc holds hi (multiply) or rem (divide); lq holds lo or quo;
  // opnd holds the multiplicand mc or the divisor dv.
  logic [31:0] acc;
  logic [31:0] lq;
  logic [31:0] opnd;
  logic [31:0] tmp;       // PH_A result carried into PH_B
  logic [31:0] addend_r;  // multiply addend, needed for the carry compare
  logic        ge;        // divide: shifted remainder >= divisor

  logic        is_div;
  logic [31:0] addend;
  logic [31:0] sh;
  logic [31:0] nxt_acc;
  logic [31:0] nxt_lq;
  logic [31:0] result_sel;

  assign is_div    = op_r[1];
  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  // ALU drive and next-value datapath, decoded from state and registers.
  always_comb begin
    alu_op   = ALU_ADD;
    alu_src1 = 32'd0;
    alu_src2 = 32'd0;
    addend   = lq[0] ? opnd : 32'd0;
    sh       = {acc[30:0], lq[31]};
    nxt_acc  = acc;
    nxt_lq   = lq;
    case (state)
      PH_A: begin
        if (is_div) begin
          alu_op   = ALU_SGEU;
          alu_src1 = sh;
          alu_src2 = opnd;
        end else begin
          alu_op   = ALU_ADD;
          alu_src1 = acc;
          alu_src2 = addend;
        end
      end
      PH_B: begin
        if (is_div) begin
          alu_op   = ALU_SUB;
          alu_src1 = tmp;
          alu_src2 = opnd;
          // Modulo-2^32 subtraction is exact here: when rem[31] forced ge,
          // the true 33-bit difference still fits in 32 bits.
          nxt_acc  = ge ? alu_result : tmp;
          nxt_lq   = {lq[30:0], ge};
        end else begin
          alu_op   = ALU_SLTU;
          alu_src1 = tmp;
          alu_src2 = addend_r;
          // Sum smaller than an addend means the add wrapped: that is the carry.
          nxt_acc  = {alu_result[0], tmp[31:1]};
          nxt_lq   = {tmp[0], lq[31:1]};
        end
      end
      default: begin
      end
    endcase
    // MUL/DIVU take the low/quotient register, MULHU/REMU the high/remainder.
    result_sel = op_r[0] ? nxt_acc : nxt_lq;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      op_r       <= 2'd0;
      cnt        <= 5'd0;
      acc        <= 32'd0;
      lq         <= 32'd0;
      opnd       <= 32'd0;
      tmp        <= 32'd0;
      addend_r   <= 32'd0;
      ge         <= 1'b0;
      resp_valid <= 1'b0;
      resp_data  <= 32'd0;
    end else if (kill) begin
      // Flush wins over everything, including a request arriving in IDLE.
      state      <= IDLE;
      resp_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            op_r <= req_op;
            cnt  <= 5'd0;
            acc  <= 32'd0;
            if (req_op[1]) begin
              lq   <= req_a;
              opnd <= req_b;
            end else begin
              lq   <= req_b;
              opnd <= req_a;
            end
            state <= PH_A;
          end
        end
        PH_A: begin
          if (is_div) begin
            // A set rem[31] means the implicit 33-bit shifted value exceeds
            // any 32-bit divisor, so subtraction is always taken.
            ge  <= acc[31] | alu_result[0];
            tmp <= sh;
          end else begin
            tmp      <= alu_result;
            addend_r <= addend;
          end
          state <= PH_B;
        end
        PH_B: begin
          acc <= nxt_acc;
          lq  <= nxt_lq;
          if (cnt == 5'd31) begin
            state      <= DONE;
            resp_valid <= 1'b1;
            resp_data  <= result_sel;
          end else begin
            cnt   <= cnt + 5'd1;
            state <= PH_A;
          end
        end
        DONE: begin
          if (resp_ready) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Testbench for muldiv_seq: models the shared ALU, drives directed and
// random operations, and scores results against plain arithmetic.
module tb_muldiv_seq;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_SLTU = 4'd3;
  localparam logic [3:0] OP_SGEU = 4'd5;

  logic        clk;
  logic        rst;
  logic        kill;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic        busy;
  logic [3:0]  alu_op;
  logic [31:0] alu_src1;
  logic [31:0] alu_src2;
  logic [31:0] alu_result;

  muldiv_seq dut (
    .clk        (clk),
    .rst        (rst),
    .kill       (kill),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .busy       (busy),
    .alu_op     (alu_op),
    .alu_src1   (alu_src1),
    .alu_src2   (alu_src2),
    .alu_result (alu_result)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- shared ALU model ----------------
  always_comb begin
    case (alu_op)
      OP_ADD:  alu_result = alu_src1 + alu_src2;
      OP_SUB:  alu_result = alu_src1 - alu_src2;
      OP_SLTU: alu_result = {31'd0, (alu_src1 < alu_src2)};
      OP_SGEU: alu_result = {31'd0, (alu_src1 >= alu_src2)};
      default: alu_result = 32'd0;
    endcase
  end

  // ---------------- reference model and checking ----------------
  int tests = 0;
  int fails = 0;
  logic [31:0] exp_q[$];
  int          acc_q[$];

  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [63:0] p;
    p = {32'd0, a} * {32'd0, b};
    case (op)
      2'b00:   return p[31:0];
      2'b01:   return p[63:32];
      2'b10:   return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: latency on the rising edge of resp_valid, data on each transfer.
  logic prev_valid = 1'b0;
  always @(negedge clk) begin
    if (resp_valid && !prev_valid) begin
      if (acc_q.size() == 0) begin
        check("resp_without_accept", 32'd1, 32'd0);
      end else begin
        check("latency", 32'(cyc - acc_q.pop_front()), 32'd64);
      end
    end
    prev_valid = resp_valid;
    if (resp_valid && resp_ready) begin
      if (exp_q.size() == 0) begin
        check("resp_unexpected", resp_data, 32'hXXXX_XXXX);
      end else begin
        check("resp_data", resp_data, exp_q.pop_front());
      end
    end
  end

  logic rand_ready = 1'b0;
  always @(posedge clk) begin
    if (rand_ready) begin
      #1 resp_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // ---------------- driver tasks ----------------
  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit expect_resp, input logic [31:0] exp);
    int t = 0;
    while (!req_ready && t < 300) begin
      @(posedge clk); #1;
      t++;
    end
    if (!req_ready) begin
      check("issue_timeout", 32'd1, 32'd0);
      return;
    end
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    if (expect_resp) exp_q.push_back(exp);
    @(posedge clk); #1;
    req_valid = 1'b0;
    if (expect_resp) acc_q.push_back(cyc);
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((exp_q.size() != 0 || busy) && t < 2000) begin
      @(posedge clk); #1;
      t++;
    end
    if (exp_q.size() != 0 || busy) check("idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, {31'd0, req_ready}, 32'd1);
    check({tag, "_resp_valid"}, {31'd0, resp_valid}, 32'd0);
    check({tag, "_resp_data"}, resp_data, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_alu_op"}, {28'd0, alu_op}, {28'd0, OP_ADD});
    check({tag, "_alu_src1"}, alu_src1, 32'd0);
    check({tag, "_alu_src2"}, alu_src2, 32'd0);
  endtask

  // Directed table: op, a, b, expected result.
  logic [1:0]  d_op [8] = '{2'b01, 2'b00, 2'b10, 2'b11, 2'b10, 2'b11, 2'b10, 2'b11};
  logic [31:0] d_a  [8] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd100, 32'd100,
                            32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'h1234, 32'h1234};
  logic [31:0] d_b  [8] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd7, 32'd7,
                            32'h8000_0001, 32'h8000_0001, 32'd0, 32'd0};
  logic [31:0] d_e  [8] = '{32'hFFFF_FFFE, 32'h0000_0001, 32'd14, 32'd2,
                            32'd1, 32'h7FFF_FFFD, 32'hFFFF_FFFF, 32'h1234};

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] held;
    logic [31:0] ra;
    logic [31:0] rb;
    logic [1:0]  rop;
    int t;

    rst        = 1'b1;
    kill       = 1'b0;
    req_valid  = 1'b0;
    req_op     = 2'b00;
    req_a      = 32'd0;
    req_b      = 32'd0;
    resp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_reset_outputs("reset");

    // MUL 7x6 with ALU op alternation ADD/SLTU over all 64 cycles.
    issue(2'b00, 32'd7, 32'd6, 1'b1, 32'd42);
    for (int i = 0; i < 64; i++) begin
      check("alu_alternate", {28'd0, alu_op}, (i % 2 == 1) ? {28'd0, OP_SLTU} : {28'd0, OP_ADD});
      @(posedge clk); #1;
    end
    wait_idle();

    // Directed corner cases, issued back to back.
    for (int i = 0; i < 8; i++) issue(d_op[i], d_a[i], d_b[i], 1'b1, d_e[i]);
    wait_idle();

    // Kill a DIVU at cycle 20, then MUL 3x5 on the next cycle.
    issue(2'b10, 32'd1000, 32'd3, 1'b0, 32'd0);
    repeat (19) begin @(posedge clk); #1; end
    kill = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0;
    check("kill_busy", {31'd0, busy}, 32'd0);
    check("kill_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("kill_req_ready", {31'd0, req_ready}, 32'd1);
    issue(2'b00, 32'd3, 32'd5, 1'b1, 32'd15);
    wait_idle();

    // A request presented together with kill must not be accepted.
    req_valid = 1'b1;
    req_op    = 2'b00;
    req_a     = 32'd9;
    req_b     = 32'd9;
    kill      = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    kill      = 1'b0;
    check("kill_priority_busy", {31'd0, busy}, 32'd0);

    // Same flow with rst mid-operation: everything returns to reset values.
    issue(2'b11, 32'hDEAD_BEEF, 32'h1234, 1'b0, 32'd0);
    repeat (19) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_reset_outputs("rst_mid");
    issue(2'b00, 32'd3, 32'd5, 1'b1, 32'd15);
    wait_idle();

    // Hold the response for 10 cycles, then release.
    resp_ready = 1'b0;
    issue(2'b01, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1, model(2'b01, 32'h1234_5678, 32'h9ABC_DEF0));
    t = 0;
    while (!resp_valid && t < 100) begin @(posedge clk); #1; t++; end
    check("stall_resp_seen", {31'd0, resp_valid}, 32'd1);
    held = resp_data;
    check("stall_data_model", held, model(2'b01, 32'h1234_5678, 32'h9ABC_DEF0));
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("stall_valid", {31'd0, resp_valid}, 32'd1);
      check("stall_data", resp_data, held);
      check("stall_req_ready", {31'd0, req_ready}, 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    check("release_valid", {31'd0, resp_valid}, 32'd0);
    check("release_req_ready", {31'd0, req_ready}, 32'd1);
    issue(2'b10, 32'd77, 32'd5, 1'b1, 32'd15);
    check("release_accept_busy", {31'd0, busy}, 32'd1);
    wait_idle();

    // Random operations with random response back-pressure.
    rand_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      rop = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0: begin ra = $urandom; rb = 32'd0; end
        1: begin ra = $urandom; rb = 32'($urandom_range(1, 300)); end
        2: begin ra = 32'hFFFF_FFFF - 32'($urandom_range(0, 3)); rb = $urandom; end
        default: begin ra = $urandom; rb = $urandom; end
      endcase
      issue(rop, ra, rb, 1'b1, model(rop, ra, rb));
    end
    wait_idle();
    rand_ready = 1'b0;
    @(posedge clk); #2;
    resp_ready = 1'b1;

    repeat (5) @(posedge clk);
    #1;
    check("drain_exp_q", 32'(exp_q.size()), 32'd0);
    check("drain_acc_q", 32'(acc_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
